operand_scoreboard: RTL and testbench



---
 rtl/operand_scoreboard_pkg.sv | 29 ++
 rtl/scb_counter.sv | 44 ++++
 rtl/operand_scoreboard.sv | 100 ++++++++++
 tb/tb_operand_scoreboard.sv | 136 +++++++++++++
 4 files changed

// File: rtl/operand_scoreboard_pkg.sv
// Shared constants and counter-operation encoding for the operand scoreboard.
package operand_scoreboard_pkg;

   localparam int unsigned NREG   = 32;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned CNT_W  = 2;

   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      CntHold = 2'd0,
      CntInc  = 2'd1,
      CntDec  = 2'd2,
      CntClr  = 2'd3
   } cnt_op_e;

   // Clear wins; simultaneous inc and dec cancel out.
   function automatic cnt_op_e cnt_op(input logic clr, input logic inc, input logic dec);
      if (clr) begin
         return CntClr;
      end else if (inc && !dec) begin
         return CntInc;
      end else if (dec && !inc) begin
         return CntDec;
      end
      return CntHold;
   endfunction

endpackage

// File: rtl/scb_counter.sv
// Saturating up/down pending-write counter for one register, with an underflow pulse
// raised when a decrement arrives while the count is already zero.
module scb_counter
   import operand_scoreboard_pkg::*;
#(
   parameter int unsigned Width = CNT_W
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] op_i,
   output logic       zero_o,
   output logic       one_o,
   output logic       sat_o,
   output logic       underflow_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == Width'(1));
   assign sat_o  = (cnt_q == '1);

   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      unique case (cnt_op_e'(op_i))
         CntInc: begin
            if (!sat_o) cnt_d = cnt_q + Width'(1);
         end
         CntDec: begin
            if (zero_o) underflow_o = 1'b1;
            else        cnt_d = cnt_q - Width'(1);
         end
         CntClr:  cnt_d = '0;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/operand_scoreboard.sv
// D-stage register read side: per-GPR in-flight write tracking, RAW stall and W->D bypass.
// Define SCB_STATS_EN to add the Stall_Cnt stall-cycle counter output.
module operand_scoreboard
   import operand_scoreboard_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              D_Valid,
   input  logic [ADDR_W-1:0] D_Rs,
   input  logic [ADDR_W-1:0] D_Rt,
   input  logic              D_UseRs,
   input  logic              D_UseRt,
   input  logic [ADDR_W-1:0] D_Dst,
   input  logic              D_DstEn,
   input  logic [31:0]       RD1_In,
   input  logic [31:0]       RD2_In,
   input  logic              W_En,
   input  logic [ADDR_W-1:0] W_Addr,
   input  logic [31:0]       W_Data,
   input  logic              Flush,
   output logic              D_Stall,
   output logic              D_Issue,
   output logic [31:0]       D_RsData,
   output logic [31:0]       D_RtData,
   output logic              Err
`ifdef SCB_STATS_EN
   ,
   output logic [31:0]       Stall_Cnt
`endif
);

   logic [NREG-1:1] zero_v, one_v, sat_v, unf_v, inc_v, dec_v;
   logic [NREG-1:0] busy_v, satf_v;
   logic            err_q, err_d;

   assign busy_v[0] = 1'b0;
   assign satf_v[0] = 1'b0;

   for (genvar r = 1; r < NREG; r++) begin : g_reg
      logic [1:0] op;

      assign inc_v[r] = D_Issue & D_DstEn & (D_Dst == ADDR_W'(r));
      assign dec_v[r] = W_En & (W_Addr == ADDR_W'(r));
      assign op       = cnt_op(Flush, inc_v[r], dec_v[r]);

      scb_counter #(
         .Width (CNT_W)
      ) u_cnt (
         .clk_i       (Clk),
         .rst_ni      (Rst),
         .op_i        (op),
         .zero_o      (zero_v[r]),
         .one_o       (one_v[r]),
         .sat_o       (sat_v[r]),
         .underflow_o (unf_v[r])
      );

      // The last outstanding write retiring this cycle is covered by the bypass.
      assign busy_v[r] = ~zero_v[r] & ~(dec_v[r] & one_v[r]);
      assign satf_v[r] = sat_v[r];
   end

   always_comb begin
      D_Stall = D_Valid & ((D_UseRs & busy_v[D_Rs]) |
                           (D_UseRt & busy_v[D_Rt]) |
                           (D_DstEn & satf_v[D_Dst]));
      D_Issue = D_Valid & ~D_Stall;
   end

   always_comb begin
      if (D_Rs == REG_ZERO)                 D_RsData = '0;
      else if (W_En && (W_Addr == D_Rs))    D_RsData = W_Data;
      else                                  D_RsData = RD1_In;

      if (D_Rt == REG_ZERO)                 D_RtData = '0;
      else if (W_En && (W_Addr == D_Rt))    D_RtData = W_Data;
      else                                  D_RtData = RD2_In;
   end

   assign err_d = err_q | (|unf_v);
   assign Err   = err_q;

   always_ff @(posedge Clk) begin
      if (!Rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

`ifdef SCB_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_d = D_Stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
   assign Stall_Cnt   = stall_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Rst) stall_cnt_q <= '0;
      else      stall_cnt_q <= stall_cnt_d;
   end
`endif

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench: stimulus pushes hand-computed expectations, a negedge monitor compares.
module tb_operand_scoreboard;

   localparam logic [31:0] RD1 = 32'h1111_1111;
   localparam logic [31:0] RD2 = 32'h2222_2222;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        D_Valid, D_UseRs, D_UseRt, D_DstEn, W_En, Flush;
   logic [4:0]  D_Rs, D_Rt, D_Dst, W_Addr;
   logic [31:0] RD1_In, RD2_In, W_Data;
   logic        D_Stall, D_Issue, Err;
   logic [31:0] D_RsData, D_RtData;
`ifdef SCB_STATS_EN
   logic [31:0] Stall_Cnt;
`endif

   operand_scoreboard dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .D_Valid  (D_Valid),
      .D_Rs     (D_Rs),
      .D_Rt     (D_Rt),
      .D_UseRs  (D_UseRs),
      .D_UseRt  (D_UseRt),
      .D_Dst    (D_Dst),
      .D_DstEn  (D_DstEn),
      .RD1_In   (RD1_In),
      .RD2_In   (RD2_In),
      .W_En     (W_En),
      .W_Addr   (W_Addr),
      .W_Data   (W_Data),
      .Flush    (Flush),
      .D_Stall  (D_Stall),
      .D_Issue  (D_Issue),
      .D_RsData (D_RsData),
      .D_RtData (D_RtData),
      .Err      (Err)
`ifdef SCB_STATS_EN
      ,
      .Stall_Cnt (Stall_Cnt)
`endif
   );

   always #5 Clk = ~Clk;

   typedef struct {
      string       nm;
      logic        stall;
      logic        issue;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (D_Stall !== e.stall || D_Issue !== e.issue || D_RsData !== e.rs ||
                D_RtData !== e.rt || Err !== e.err) begin
               errors++;
               $display("FAIL %s: got stall=%b issue=%b rs=%h rt=%h err=%b, want stall=%b issue=%b rs=%h rt=%h err=%b",
                        e.nm, D_Stall, D_Issue, D_RsData, D_RtData, Err,
                        e.stall, e.issue, e.rs, e.rt, e.err);
            end
         end
      end
   end

   task automatic step(input string nm, input logic rst, input logic vld, input logic urs,
                       input logic [4:0] rs, input logic urt, input logic [4:0] rt,
                       input logic den, input logic [4:0] dst, input logic wen,
                       input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                       input logic e_stall, input logic e_issue, input logic [31:0] e_rs,
                       input logic [31:0] e_rt, input logic e_err);
      exp_t e;
      @(posedge Clk);
      #1;
      Rst = rst; D_Valid = vld; D_UseRs = urs; D_Rs = rs; D_UseRt = urt; D_Rt = rt;
      D_DstEn = den; D_Dst = dst; W_En = wen; W_Addr = wa; W_Data = wd; Flush = fl;
      e.nm = nm; e.stall = e_stall; e.issue = e_issue; e.rs = e_rs; e.rt = e_rt; e.err = e_err;
      exp_q.push_back(e);
   endtask

   initial begin : stim
      Rst = 1'b0; D_Valid = 0; D_UseRs = 0; D_UseRt = 0; D_DstEn = 0; W_En = 0; Flush = 0;
      D_Rs = 0; D_Rt = 0; D_Dst = 0; W_Addr = 0; W_Data = 0;
      RD1_In = RD1; RD2_In = RD2;
      repeat (2) @(posedge Clk);
      //      name          rst vld urs rs urt rt den dst wen wa wd            fl  stl iss rs      rt   err
      step("rst_rd5",        0,  1,  1, 5, 0, 0,  0, 0,  0,  0, 32'h0,        0,  0,  1, RD1,    0,   0);
      step("rd5",            1,  1,  1, 5, 0, 0,  0, 0,  0,  0, 32'h0,        0,  0,  1, RD1,    0,   0);
      step("iss_r8",         1,  1,  0, 0, 0, 0,  1, 8,  0,  0, 32'h0,        0,  0,  1, 0,      0,   0);
      step("stall_r8",       1,  1,  1, 8, 0, 0,  0, 0,  0,  0, 32'h0,        0,  1,  0, RD1,    0,   0);
      step("bypass_r8",      1,  1,  1, 8, 0, 0,  0, 0,  1,  8, 32'hDEAD,     0,  0,  1, 32'hDEAD, 0, 0);
      step("iss9_a",         1,  1,  0, 0, 0, 0,  1, 9,  0,  0, 32'h0,        0,  0,  1, 0,      0,   0);
      step("iss9_b",         1,  1,  0, 0, 0, 0,  1, 9,  0,  0, 32'h0,        0,  0,  1, 0,      0,   0);
      step("iss9_c",         1,  1,  0, 0, 0, 0,  1, 9,  0,  0, 32'h0,        0,  0,  1, 0,      0,   0);
      step("sat9",           1,  1,  0, 0, 0, 0,  1, 9,  0,  0, 32'h0,        0,  1,  0, 0,      0,   0);
      step("sat9_retire",    1,  1,  0, 0, 0, 0,  1, 9,  1,  9, 32'h99,       0,  1,  0, 0,      0,   0);
      step("iss9_d",         1,  1,  0, 0, 0, 0,  1, 9,  0,  0, 32'h0,        0,  0,  1, 0,      0,   0);
      step("sat9_again",     1,  1,  0, 0, 0, 0,  1, 9,  0,  0, 32'h0,        0,  1,  0, 0,      0,   0);
      step("iss_r4",         1,  1,  0, 0, 0, 0,  1, 4,  0,  0, 32'h0,        0,  0,  1, 0,      0,   0);
      step("iss_ret_r4",     1,  1,  1, 4, 0, 0,  1, 4,  1,  4, 32'h44,       0,  0,  1, 32'h44, 0,   0);
      step("rd4_stall",      1,  1,  1, 4, 0, 0,  0, 0,  0,  0, 32'h0,        0,  1,  0, RD1,    0,   0);
      step("underflow_r3",   1,  0,  0, 0, 0, 0,  0, 0,  1,  3, 32'h33,       0,  0,  0, 0,      0,   0);
      step("err_rd0_r3",     1,  1,  1, 0, 1, 3,  0, 0,  1,  0, 32'h55,       0,  0,  1, 0,      RD2, 1);
      step("iss_r2",         1,  1,  0, 0, 0, 0,  1, 2,  0,  0, 32'h0,        0,  0,  1, 0,      0,   1);
      step("iss_r7",         1,  1,  0, 0, 0, 0,  1, 7,  0,  0, 32'h0,        0,  0,  1, 0,      0,   1);
      step("flush",          1,  1,  1, 2, 0, 0,  0, 0,  0,  0, 32'h0,        1,  1,  0, RD1,    0,   1);
      step("post_flush",     1,  1,  1, 2, 1, 7,  0, 0,  0,  0, 32'h0,        0,  0,  1, RD1,    RD2, 1);
      step("post_flush_9_4", 1,  1,  1, 4, 0, 0,  1, 9,  0,  0, 32'h0,        0,  0,  1, RD1,    0,   1);
      step("stall_r9",       1,  1,  1, 9, 0, 0,  0, 0,  0,  0, 32'h0,        0,  1,  0, RD1,    0,   1);
      step("rst_mid_stall",  0,  1,  1, 9, 0, 0,  0, 0,  0,  0, 32'h0,        0,  1,  0, RD1,    0,   1);
      step("after_rst",      1,  1,  1, 9, 0, 0,  0, 0,  0,  0, 32'h0,        0,  0,  1, RD1,    0,   0);
      step("flush_vs_inc",   1,  1,  0, 0, 0, 0,  1, 6,  0,  0, 32'h0,        1,  0,  1, 0,      0,   0);
      step("rd6_clear",      1,  1,  1, 6, 0, 0,  0, 0,  0,  0, 32'h0,        0,  0,  1, RD1,    0,   0);
      repeat (3) @(posedge Clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
